// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Types shared by the register file and its clear sequencer.
//   regfile_state_t : clear-sweep FSM states (CLEAR while zeroing, READY after).
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } regfile_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_clr_seq.sv
// -----------------------------------------------------------------------------
// regfile_clr_seq
//   Post-reset clear sequencer. After rst deasserts it walks a pointer from 0
//   to DEPTH-1, requesting a zero write to each entry, one entry per cycle.
//   When the last entry is written the FSM moves to READY and stays there
//   until the next reset.
//
// Parameters
//   ADDR_W    address width; the sweep covers 2**ADDR_W entries
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset; restarts the sweep at 0
//   clr_we    out  clear write request (high for the whole sweep)
//   clr_addr  out  entry being cleared this cycle
//   ready     out  high once the sweep has finished
// -----------------------------------------------------------------------------
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    regfile_state_t    state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves a variable unassigned would infer a latch.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        clr_we     = 1'b0;
        unique case (state)
            CLEAR: begin
                clr_we   = 1'b1;
                ptr_next = ptr + ADDR_W'(1);
                // The edge that clears the last entry also raises ready.
                if (ptr == LAST_ADDR) begin
                    state_next = READY;
                end
            end
            READY: begin
                ptr_next = ptr;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign clr_addr = ptr;
    assign ready    = (state == READY);

endmodule : regfile_clr_seq

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//   Parametrised register file: two registered read ports, one write port.
//   After reset an internal sequencer zeroes every entry (DEPTH cycles);
//   user writes are ignored and read data is held at 0 until ready rises.
//
// Configuration macro
//   REGFILE_BYPASS_EN  defined   : write-first; a same-cycle write to the
//                                  address being read is forwarded.
//                      undefined : read-first; a same-cycle read returns the
//                                  old contents. No forwarding logic exists.
//
// Parameters
//   DATA_W    register width
//   ADDR_W    address width, DEPTH = 2**ADDR_W (derived, not overridable)
//   ZERO_REG  1: entry 0 always reads 0 and writes to it are discarded
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   wr_en      in   write strobe
//   wr_reg     in   write address
//   wr_data    in   write data
//   rd_reg1    in   read address, port 1
//   rd_reg2    in   read address, port 2
//   reg_data1  out  registered read data, port 1 (1-cycle latency)
//   reg_data2  out  registered read data, port 2 (1-cycle latency)
//   ready      out  clear sweep complete, file usable
// -----------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic [DATA_W-1:0] reg_data1,
    output logic [DATA_W-1:0] reg_data2,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // ------------------------------------------------------------------
    // Write port: the clear sweep owns the array until ready; afterwards
    // user writes go through, minus writes to a hard-wired zero entry.
    // ------------------------------------------------------------------
    logic              wr_zero_blk;
    logic              user_we;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_data;

    assign wr_zero_blk = (ZERO_REG != 0) && (wr_reg == '0);
    assign user_we     = ready && wr_en && !wr_zero_blk;

    always_comb begin
        arr_we   = 1'b0;
        arr_addr = wr_reg;
        arr_data = wr_data;
        if (clr_we) begin
            arr_we   = 1'b1;
            arr_addr = clr_addr;
            arr_data = '0;
        end else if (user_we) begin
            arr_we = 1'b1;
        end
    end

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch; the clear sweep zeroes it, which
    // keeps it mappable onto plain RAM/flop arrays without reset wiring.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem[arr_addr] <= arr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read value selection per port.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_val1, rd_val2;

    always_comb begin
        rd_val1 = mem[rd_reg1];
        rd_val2 = mem[rd_reg2];
`ifdef REGFILE_BYPASS_EN
        // Write-first: forward the word being written this cycle.
        if (wr_en && (wr_reg == rd_reg1)) begin
            rd_val1 = wr_data;
        end
        if (wr_en && (wr_reg == rd_reg2)) begin
            rd_val2 = wr_data;
        end
`endif
        // Zero-register suppression overrides forwarding.
        if ((ZERO_REG != 0) && (rd_reg1 == '0)) begin
            rd_val1 = '0;
        end
        if ((ZERO_REG != 0) && (rd_reg2 == '0)) begin
            rd_val2 = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registered read ports: zero under reset and during the sweep.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_data1 <= '0;
            reg_data2 <= '0;
        end else if (!ready) begin
            reg_data1 <= '0;
            reg_data2 <= '0;
        end else begin
            reg_data1 <= rd_val1;
            reg_data2 <= rd_val2;
        end
    end

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// tb_regfile_2r1w
//   Directed self-checking bench for regfile_2r1w. Three instances:
//     u_dut   : DATA_W=8,  ADDR_W=3, ZERO_REG=0
//     u_dut_z : DATA_W=8,  ADDR_W=3, ZERO_REG=1
//     u_dut_w : DATA_W=16, ADDR_W=5, ZERO_REG=0
//   Expectations for same-cycle write/read follow REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile_2r1w;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 8x8 instance
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_reg, rd_reg1, rd_reg2;
    logic [7:0]  wr_data, reg_data1, reg_data2;
    logic        ready;

    // 8x8 zero-register instance
    logic        rst_z;
    logic        wr_en_z;
    logic [2:0]  wr_reg_z, rd_reg1_z, rd_reg2_z;
    logic [7:0]  wr_data_z, reg_data1_z, reg_data2_z;
    logic        ready_z;

    // 32x16 instance
    logic        rst_w;
    logic        wr_en_w;
    logic [4:0]  wr_reg_w, rd_reg1_w, rd_reg2_w;
    logic [15:0] wr_data_w, reg_data1_w, reg_data2_w;
    logic        ready_w;

    regfile_2r1w #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) u_dut (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_reg (wr_reg),
        .wr_data (wr_data), .rd_reg1 (rd_reg1), .rd_reg2 (rd_reg2),
        .reg_data1 (reg_data1), .reg_data2 (reg_data2), .ready (ready)
    );

    regfile_2r1w #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) u_dut_z (
        .clk (clk), .rst (rst_z), .wr_en (wr_en_z), .wr_reg (wr_reg_z),
        .wr_data (wr_data_z), .rd_reg1 (rd_reg1_z), .rd_reg2 (rd_reg2_z),
        .reg_data1 (reg_data1_z), .reg_data2 (reg_data2_z), .ready (ready_z)
    );

    regfile_2r1w #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(0)) u_dut_w (
        .clk (clk), .rst (rst_w), .wr_en (wr_en_w), .wr_reg (wr_reg_w),
        .wr_data (wr_data_w), .rd_reg1 (rd_reg1_w), .rd_reg2 (rd_reg2_w),
        .reg_data1 (reg_data1_w), .reg_data2 (reg_data2_w), .ready (ready_w)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] same_cycle_exp;
    int         cnt;

    initial begin
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 8'hA5;
`else
        same_cycle_exp = 8'h00;
`endif
        rst = 1'b1; rst_z = 1'b1; rst_w = 1'b1;
        wr_en = 1'b0;   wr_reg = '0;   wr_data = '0;   rd_reg1 = '0;   rd_reg2 = '0;
        wr_en_z = 1'b0; wr_reg_z = '0; wr_data_z = '0; rd_reg1_z = '0; rd_reg2_z = '0;
        wr_en_w = 1'b0; wr_reg_w = '0; wr_data_w = '0; rd_reg1_w = '0; rd_reg2_w = '0;
        tick();
        tick();

        // ---------------- reset state ----------------
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_d1", 32'(reg_data1), 32'h0);
        check("rst_d2", 32'(reg_data2), 32'h0);

        // ---- sweep length; write to reg 2 on sweep cycle 3 must be ignored ----
        rst = 1'b0;
        cnt = 0;
        while (!ready && cnt < 100) begin
            if (cnt == 2) begin
                wr_en = 1'b1; wr_reg = 3'd2; wr_data = 8'h55;
            end else begin
                wr_en = 1'b0;
            end
            check("sweep_d1_held", 32'(reg_data1), 32'h0);
            tick();
            cnt++;
        end
        wr_en = 1'b0;
        check("sweep_cycles", 32'(cnt), 32'd8);

        // ---------------- all entries read 0 ----------------
        for (int a = 0; a < 8; a++) begin
            rd_reg1 = 3'(a);
            rd_reg2 = 3'(7 - a);
            tick();
            check($sformatf("clr_d1[%0d]", a), 32'(reg_data1), 32'h0);
            check($sformatf("clr_d2[%0d]", 7 - a), 32'(reg_data2), 32'h0);
        end

        // ---------------- same-cycle write/read of reg 3 ----------------
        wr_en = 1'b1; wr_reg = 3'd3; wr_data = 8'hA5;
        rd_reg1 = 3'd3; rd_reg2 = 3'd3;
        tick();
        wr_en = 1'b0;
        check("wr_rd_same_d1", 32'(reg_data1), 32'(same_cycle_exp));
        check("wr_rd_same_d2", 32'(reg_data2), 32'(same_cycle_exp));
        tick();
        check("wr_rd_next_d1", 32'(reg_data1), 32'hA5);
        check("wr_rd_next_d2", 32'(reg_data2), 32'hA5);

        // ---------------- distinct data per entry ----------------
        for (int a = 0; a < 8; a++) begin
            wr_en = 1'b1; wr_reg = 3'(a); wr_data = 8'(8'h40 + a * 8'h13);
            tick();
        end
        wr_en = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd_reg1 = 3'(a);
            rd_reg2 = 3'((a + 3) % 8);
            tick();
            check($sformatf("pat_d1[%0d]", a), 32'(reg_data1), 32'(8'(8'h40 + a * 8'h13)));
            check($sformatf("pat_d2[%0d]", (a + 3) % 8), 32'(reg_data2),
                  32'(8'(8'h40 + ((a + 3) % 8) * 8'h13)));
        end

        // ---------------- fill with 0x11, then reset in READY ----------------
        for (int a = 0; a < 8; a++) begin
            wr_en = 1'b1; wr_reg = 3'(a); wr_data = 8'h11;
            tick();
        end
        wr_en = 1'b0;
        rd_reg1 = 3'd5; rd_reg2 = 3'd0;
        tick();
        check("fill_d1", 32'(reg_data1), 32'h11);
        check("fill_d2", 32'(reg_data2), 32'h11);

        rst = 1'b1;
        #1;
        check("rst2_ready", 32'(ready), 32'h0);
        check("rst2_d1", 32'(reg_data1), 32'h0);
        check("rst2_d2", 32'(reg_data2), 32'h0);
        tick();
        rst = 1'b0;
        cnt = 0;
        while (!ready && cnt < 100) begin
            tick();
            cnt++;
        end
        check("sweep2_cycles", 32'(cnt), 32'd8);
        for (int a = 0; a < 8; a++) begin
            rd_reg1 = 3'(a);
            rd_reg2 = 3'(7 - a);
            tick();
            check($sformatf("clr2_d1[%0d]", a), 32'(reg_data1), 32'h0);
            check($sformatf("clr2_d2[%0d]", 7 - a), 32'(reg_data2), 32'h0);
        end

        // ---------------- ZERO_REG=1 instance ----------------
        rst_z = 1'b0;
        cnt = 0;
        while (!ready_z && cnt < 100) begin
            tick();
            cnt++;
        end
        check("z_sweep_cycles", 32'(cnt), 32'd8);
        wr_en_z = 1'b1; wr_reg_z = 3'd0; wr_data_z = 8'hFF;
        rd_reg1_z = 3'd0; rd_reg2_z = 3'd0;
        tick();
        check("z_same_d1", 32'(reg_data1_z), 32'h0);
        wr_reg_z = 3'd7; wr_data_z = 8'h3C;
        tick();
        wr_en_z = 1'b0;
        rd_reg1_z = 3'd0; rd_reg2_z = 3'd7;
        tick();
        check("z_r0_d1", 32'(reg_data1_z), 32'h0);
        check("z_r7_d2", 32'(reg_data2_z), 32'h3C);
        rd_reg1_z = 3'd7; rd_reg2_z = 3'd0;
        tick();
        check("z_r7_d1", 32'(reg_data1_z), 32'h3C);
        check("z_r0_d2", 32'(reg_data2_z), 32'h0);

        // ---------------- DATA_W=16, ADDR_W=5 instance ----------------
        rst_w = 1'b0;
        cnt = 0;
        while (!ready_w && cnt < 200) begin
            tick();
            cnt++;
        end
        check("w_sweep_cycles", 32'(cnt), 32'd32);
        for (int a = 0; a < 32; a++) begin
            wr_en_w = 1'b1; wr_reg_w = 5'(a); wr_data_w = 16'(a * 16'h0101);
            tick();
        end
        wr_en_w = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_reg1_w = 5'(a);
            rd_reg2_w = 5'((a + 5) % 32);
            tick();
            check($sformatf("w_d1[%0d]", a), 32'(reg_data1_w), 32'(16'(a * 16'h0101)));
            check($sformatf("w_d2[%0d]", (a + 5) % 32), 32'(reg_data2_w),
                  32'(16'(((a + 5) % 32) * 16'h0101)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_regfile_2r1w
